// File: rtl/button_input_reader_if.sv
// Button reader bus: raw buttons and count clear in, debounced state, edge pulses and press count out.
interface button_input_reader_if #(
  parameter int unsigned COUNT_WIDTH = 8
);
  logic [3:0]             Button;
  logic                   CountClear;
  logic [3:0]             ButtonState;
  logic [3:0]             ButtonPressed;
  logic [3:0]             ButtonReleased;
  logic [COUNT_WIDTH-1:0] PressCount;

  modport master (
    output Button, CountClear,
    input  ButtonState, ButtonPressed, ButtonReleased, PressCount
  );

  modport slave (
    input  Button, CountClear,
    output ButtonState, ButtonPressed, ButtonReleased, PressCount
  );
endinterface

// File: rtl/button_input_reader.sv
// Four-button reader: per-bit 2-flop synchronizer, counter-based debounce,
// registered press/release pulses and a wrapping press counter.
module button_input_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input logic                  Clock,
  input logic                  Reset,
  button_input_reader_if.slave bus
);

  localparam int unsigned LP_NB    = 4;
  localparam int unsigned LP_CW    = 16;
  localparam logic [LP_CW-1:0] LP_LIMIT = LP_CW'(DEBOUNCE_CYCLES - 1);

  logic [LP_NB-1:0]             r_sync1;
  logic [LP_NB-1:0]             r_sync2;
  logic [LP_NB-1:0]             w_level;
  logic [LP_NB-1:0][LP_CW-1:0]  r_cnt;
  logic [LP_NB-1:0][LP_CW-1:0]  w_cnt_nxt;
  logic [LP_NB-1:0]             r_state;
  logic [LP_NB-1:0]             w_state_nxt;
  logic [LP_NB-1:0]             r_pressed;
  logic [LP_NB-1:0]             w_pressed_nxt;
  logic [LP_NB-1:0]             r_released;
  logic [LP_NB-1:0]             w_released_nxt;
  logic [COUNT_WIDTH-1:0]       r_count;
  logic [COUNT_WIDTH-1:0]       w_count_nxt;
  logic [2:0]                   w_press_sum;

  // Buttons are active-low, so the pressed level is the inverted synchronizer output
  assign w_level = ~r_sync2;

  // Per-bit debounce: the level must differ from the accepted state for DEBOUNCE_CYCLES cycles
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_state_nxt    = r_state;
    w_pressed_nxt  = '0;
    w_released_nxt = '0;
    for (int i = 0; i < int'(LP_NB); i++) begin
      if (w_level[i] == r_state[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == LP_LIMIT) begin
        w_cnt_nxt[i]      = '0;
        w_state_nxt[i]    = w_level[i];
        w_pressed_nxt[i]  = w_level[i];
        w_released_nxt[i] = ~w_level[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + LP_CW'(1);
      end
    end
  end

  // Press counter adds last cycle's press pulses; clear takes priority
  always_comb begin
    w_press_sum = 3'(r_pressed[0]) + 3'(r_pressed[1]) + 3'(r_pressed[2]) + 3'(r_pressed[3]);
    w_count_nxt = r_count + COUNT_WIDTH'(w_press_sum);
    if (bus.CountClear) begin
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_cnt      <= '0;
      r_state    <= '0;
      r_pressed  <= '0;
      r_released <= '0;
      r_count    <= '0;
    end else begin
      r_sync1    <= bus.Button;
      r_sync2    <= r_sync1;
      r_cnt      <= w_cnt_nxt;
      r_state    <= w_state_nxt;
      r_pressed  <= w_pressed_nxt;
      r_released <= w_released_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign bus.ButtonState    = r_state;
  assign bus.ButtonPressed  = r_pressed;
  assign bus.ButtonReleased = r_released;
  assign bus.PressCount     = r_count;

endmodule

// File: tb/tb_button_input_reader.sv
// Bench for button_input_reader: directed scenarios plus random button activity,
// all outputs compared every cycle against a window-based reference model.
module tb_button_input_reader;

  localparam int unsigned D  = 4;
  localparam int unsigned CW = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  button_input_reader_if #(.COUNT_WIDTH(CW)) bus ();

  button_input_reader #(
    .DEBOUNCE_CYCLES(D),
    .COUNT_WIDTH    (CW)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the pressed level seen at an edge is the inverse of the raw
  // sample two edges earlier; a bit flips once its last D levels since reset all
  // disagree with the current state.
  logic [3:0]    m_raw1, m_raw2, m_lvl, m_fire, m_state, m_pr, m_rel;
  logic [CW-1:0] m_cnt;
  logic [3:0]    m_hist[$];
  logic          m_all;

  always @(posedge Clock) begin
    if (!Reset) begin
      m_raw1 = 4'hF;
      m_raw2 = 4'hF;
      m_hist.delete();
      m_state = '0;
      m_pr    = '0;
      m_rel   = '0;
      m_cnt   = '0;
    end else begin
      m_lvl  = ~m_raw2;
      m_raw2 = m_raw1;
      m_raw1 = bus.Button;
      m_hist.push_back(m_lvl);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      m_fire = '0;
      for (int b = 0; b < 4; b++) begin
        m_all = (m_hist.size() == D);
        foreach (m_hist[j]) if (m_hist[j][b] == m_state[b]) m_all = 1'b0;
        m_fire[b] = m_all;
      end
      m_cnt   = bus.CountClear ? '0 : m_cnt + CW'($countones(m_pr));
      m_pr    = m_fire & m_lvl;
      m_rel   = m_fire & ~m_lvl;
      m_state = m_state ^ m_fire;
    end
    #1;
    chk("state",    32'(bus.ButtonState),    32'(m_state));
    chk("pressed",  32'(bus.ButtonPressed),  32'(m_pr));
    chk("released", 32'(bus.ButtonReleased), 32'(m_rel));
    chk("count",    32'(bus.PressCount),     32'(m_cnt));
  end

  task automatic sample_edge();
    @(posedge Clock);
    #2;
  endtask

  task automatic wait_press(input int b, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      sample_edge();
      if (bus.ButtonPressed[b]) seen = 1'b1;
    end
    if (!seen) chk(tag, 32'd0, 32'd1);
  endtask

  int hold[4];

  initial begin
    bus.Button     = 4'hF;
    bus.CountClear = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_state", 32'(bus.ButtonState), 32'd0);
    chk("rst_count", 32'(bus.PressCount),  32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);

    // Clean press of bit 0: six edges to accept, count one edge later
    bus.Button = 4'b1110;
    repeat (5) sample_edge();
    chk("press_early", 32'(bus.ButtonState), 32'd0);
    sample_edge();
    chk("press_state", 32'(bus.ButtonState),   32'h1);
    chk("press_pulse", 32'(bus.ButtonPressed), 32'h1);
    sample_edge();
    chk("press_pulse_end", 32'(bus.ButtonPressed), 32'h0);
    chk("press_count",     32'(bus.PressCount),    32'd1);
    @(negedge Clock);
    bus.Button = 4'hF;
    repeat (12) @(negedge Clock);

    // Three-cycle glitch on bit 2 is rejected
    bus.Button = 4'b1011;
    repeat (3) @(negedge Clock);
    bus.Button = 4'hF;
    repeat (10) @(negedge Clock);
    chk("glitch_state", 32'(bus.ButtonState), 32'd0);
    chk("glitch_count", 32'(bus.PressCount),  32'd1);

    // All four together
    bus.Button = 4'h0;
    repeat (6) sample_edge();
    chk("all_pressed", 32'(bus.ButtonPressed), 32'hF);
    sample_edge();
    chk("all_count", 32'(bus.PressCount), 32'd5);
    @(negedge Clock);
    bus.Button = 4'hF;
    repeat (6) sample_edge();
    chk("all_released", 32'(bus.ButtonReleased), 32'hF);
    sample_edge();
    chk("all_count_rel", 32'(bus.PressCount), 32'd5);

    // Clear, then 257 presses wrap to 1
    @(negedge Clock);
    bus.CountClear = 1'b1;
    @(negedge Clock);
    bus.CountClear = 1'b0;
    chk("clear", 32'(bus.PressCount), 32'd0);
    for (int k = 0; k < 257; k++) begin
      bus.Button = 4'b1101;
      repeat (8) @(negedge Clock);
      bus.Button = 4'hF;
      repeat (8) @(negedge Clock);
    end
    chk("wrap", 32'(bus.PressCount), 32'd1);

    // Clear on the increment edge drops that press
    @(negedge Clock);
    bus.Button = 4'b1101;
    wait_press(1, "clear_press_timeout");
    @(negedge Clock);
    bus.CountClear = 1'b1;
    @(negedge Clock);
    bus.CountClear = 1'b0;
    chk("clear_wins", 32'(bus.PressCount), 32'd0);
    bus.Button = 4'hF;
    repeat (10) @(negedge Clock);

    // Random activity with sporadic clears and resets
    foreach (hold[b]) hold[b] = $urandom_range(1, 8);
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          bus.Button[b] = ~bus.Button[b];
          hold[b] = $urandom_range(1, 8);
        end
      end
      bus.CountClear = ($urandom_range(0, 39) == 0);
      Reset = !Reset ? 1'b1 : ($urandom_range(0, 599) != 0);
    end
    @(negedge Clock);
    Reset          = 1'b1;
    bus.CountClear = 1'b0;
    bus.Button     = 4'hF;
    repeat (20) @(negedge Clock);

    // Reset during a bit-3 debounce restarts the full latency
    bus.Button = 4'b0111;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("midrst_state",    32'(bus.ButtonState),    32'd0);
    chk("midrst_pressed",  32'(bus.ButtonPressed),  32'd0);
    chk("midrst_released", 32'(bus.ButtonReleased), 32'd0);
    chk("midrst_count",    32'(bus.PressCount),     32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (5) sample_edge();
    chk("midrst_early", 32'(bus.ButtonPressed), 32'd0);
    sample_edge();
    chk("midrst_pulse", 32'(bus.ButtonPressed), 32'h8);
    sample_edge();
    chk("midrst_count_after", 32'(bus.PressCount), 32'd1);
    @(negedge Clock);
    bus.Button = 4'hF;
    repeat (10) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_input_reader.md
BUTTON_INPUT_READER -- requirements
Module: button_input_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive cycles a synchronized input must differ from stable state before acceptance (legal range 2..65535).
REQ-002 SHALL have parameter COUNT_WIDTH, default 8, meaning width of PressCount.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Button  input  4  raw board buttons, active-low (0 = pressed), asynchronous to Clock.
REQ-006 SHALL have port CountClear  input  1  synchronous clear of PressCount, active-high.
REQ-007 SHALL have port ButtonState  output  4  debounced state, active-high (1 = pressed).
REQ-008 SHALL have port ButtonPressed  output  4  one-cycle pulse per bit on debounced press.
REQ-009 SHALL have port ButtonReleased  output  4  one-cycle pulse per bit on debounced release.
REQ-010 SHALL have port PressCount  output  COUNT_WIDTH  running total of debounced presses.

Function
REQ-011 SHALL pass each Button bit through its own two-flop synchronizer; the synchronized pressed level is the inverted second-flop value.
REQ-012 SHALL keep a 16-bit debounce counter per bit, independent across bits.
REQ-013 SHALL, per bit, when synchronized level equals ButtonState: counter <= 0.
REQ-014 SHALL, per bit, when synchronized level differs from ButtonState and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
REQ-015 SHALL, per bit, when synchronized level differs and counter == DEBOUNCE_CYCLES-1: ButtonState <= synchronized level, counter <= 0, and assert the matching pulse on the same edge.
REQ-016 SHALL deliver a clean input transition to ButtonState exactly 2 + DEBOUNCE_CYCLES rising edges after the edge that first samples it.
REQ-017 SHALL discard any glitch held for fewer than DEBOUNCE_CYCLES synchronized cycles (counter returns to 0, no state change, no pulse).
REQ-018 SHALL drive ButtonPressed[i] = 1 for exactly one cycle when ButtonState[i] goes 0->1, ButtonReleased[i] likewise for 1->0; both registered; never both high on one bit.
REQ-019 SHALL add the number of ButtonPressed bits set (0..4) to PressCount on the edge after those pulses, modulo 2^COUNT_WIDTH (wraps, no saturation, no flag).
REQ-020 SHALL, when CountClear is high, load PressCount with 0 on that edge; clear wins over any simultaneous increment, and those presses are not counted.
REQ-021 SHALL debounce simultaneous transitions on multiple bits in parallel with identical latency.

Reset
REQ-022 SHALL, while Reset is low, force synchronizer flops to 1 (released), debounce counters to 0, ButtonState 0, ButtonPressed 0, ButtonReleased 0, PressCount 0, independent of Clock.
REQ-023 SHALL, on Reset asserted mid-debounce, discard the partial count; after release a still-held button requires a full 2 + DEBOUNCE_CYCLES cycles and then produces one press pulse.
REQ-024 SHALL produce no pulses in the first cycle after reset release.

Verification (DEBOUNCE_CYCLES = 4, COUNT_WIDTH = 8)
REQ-025 SHALL cover clean press: Button[0] 1->0 and held -> ButtonState[0] = 1 and ButtonPressed = 4'b0001 for one cycle, 6 edges after first sample; PressCount = 1 one edge later.
REQ-026 SHALL cover glitch rejection: Button[2] low for 3 cycles then high -> ButtonState, pulses and PressCount remain 0.
REQ-027 SHALL cover simultaneous press: all four bits pressed on one edge -> ButtonPressed = 4'hF for one cycle, PressCount 0 -> 4; release all -> ButtonReleased = 4'hF, PressCount unchanged.
REQ-028 SHALL cover wrap and clear: 257 debounced presses of Button[1] -> PressCount = 1; CountClear high on the increment edge of the next press -> PressCount = 0.
REQ-029 SHALL cover reset mid-debounce: Button[3] held low, Reset low after 2 synchronized cycles for 1 cycle -> all outputs 0; press pulse appears exactly 6 edges after reset release.
